// File: rtl/mt8816_switch_model.sv
// Responder model of two MT8816 16x8 crosspoint switches: holds both matrices,
// exposes row readback and flags bus-timing violations made by the driver.
module mt8816_switch_model #(
    parameter int unsigned MIN_STROBE = 3,
    parameter int unsigned MIN_SETUP  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RESET_SW1,
    input  logic             CS_SW1,
    input  logic             RESET_SW2,
    input  logic             CS_SW2,
    input  logic [3:0]       AX,
    input  logic [2:0]       AY,
    input  logic             STROBE,
    input  logic             DATA,
    input  logic             rd_chip,
    input  logic [3:0]       rd_ax,
    output logic [7:0]       rd_row,
    input  logic             clr_err,
    output logic [3:0]       err,
    output logic [CNT_W-1:0] commit_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StStrobeHi, StCommit} state_e;

    localparam logic [7:0] MinStrobe = 8'(MIN_STROBE);
    localparam logic [7:0] MinSetup  = 8'(MIN_SETUP);

    logic             reset_sw1_q, reset_sw2_q, cs_sw1_q, cs_sw2_q;
    logic             strobe_q, strobe_prev_q, data_q;
    logic [3:0]       ax_q;
    logic [2:0]       ay_q;

    state_e           state_q;
    logic             busy_q;
    logic [7:0]       setup_cnt_q, strobe_cnt_q;
    logic             cap_chip_q, cap_cs1_q, cap_cs2_q, cap_data_q, cap_bad_q;
    logic [3:0]       cap_ax_q;
    logic [2:0]       cap_ay_q;

    logic [7:0]       mat_q [2][16];
    logic [7:0]       rd_row_q;
    logic [3:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic strobe_rise, strobe_fall, one_cs, both_cs, setup_bad, bus_changed;
    logic chip_reset, do_commit;

    // Every bus pin passes through exactly one register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reset_sw1_q   <= 1'b0;
            reset_sw2_q   <= 1'b0;
            cs_sw1_q      <= 1'b0;
            cs_sw2_q      <= 1'b0;
            strobe_q      <= 1'b0;
            strobe_prev_q <= 1'b0;
            data_q        <= 1'b0;
            ax_q          <= '0;
            ay_q          <= '0;
        end else begin
            reset_sw1_q   <= RESET_SW1;
            reset_sw2_q   <= RESET_SW2;
            cs_sw1_q      <= CS_SW1;
            cs_sw2_q      <= CS_SW2;
            strobe_q      <= STROBE;
            strobe_prev_q <= strobe_q;
            data_q        <= DATA;
            ax_q          <= AX;
            ay_q          <= AY;
        end
    end

    always_comb begin
        strobe_rise = strobe_q & ~strobe_prev_q;
        strobe_fall = ~strobe_q & strobe_prev_q;
        one_cs      = cs_sw1_q ^ cs_sw2_q;
        both_cs     = cs_sw1_q & cs_sw2_q;
        setup_bad   = !(cs_sw1_q | cs_sw2_q) || (setup_cnt_q < MinSetup);
        bus_changed = strobe_q && ((ax_q != cap_ax_q) || (ay_q != cap_ay_q) ||
                                   (data_q != cap_data_q) || (cs_sw1_q != cap_cs1_q) ||
                                   (cs_sw2_q != cap_cs2_q));
        chip_reset  = cap_chip_q ? reset_sw2_q : reset_sw1_q;
        do_commit   = (state_q == StCommit) && !cap_bad_q && !chip_reset;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            setup_cnt_q  <= '0;
            strobe_cnt_q <= '0;
            cap_chip_q   <= 1'b0;
            cap_cs1_q    <= 1'b0;
            cap_cs2_q    <= 1'b0;
            cap_data_q   <= 1'b0;
            cap_bad_q    <= 1'b0;
            cap_ax_q     <= '0;
            cap_ay_q     <= '0;
        end else begin
            if (!one_cs) begin
                setup_cnt_q <= '0;
            end else if (setup_cnt_q != 8'hff) begin
                setup_cnt_q <= setup_cnt_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (strobe_rise) begin
                        state_q      <= StStrobeHi;
                        busy_q       <= 1'b1;
                        cap_chip_q   <= cs_sw2_q;
                        cap_cs1_q    <= cs_sw1_q;
                        cap_cs2_q    <= cs_sw2_q;
                        cap_data_q   <= data_q;
                        cap_ax_q     <= ax_q;
                        cap_ay_q     <= ay_q;
                        cap_bad_q    <= setup_bad;
                        strobe_cnt_q <= 8'd1;
                    end
                end
                StStrobeHi: begin
                    if (strobe_fall) begin
                        state_q <= StCommit;
                    end else if (strobe_q && strobe_cnt_q != 8'hff) begin
                        strobe_cnt_q <= strobe_cnt_q + 8'd1;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Chip reset is applied after the commit so it overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 16; x++) begin
                    mat_q[c][x] <= '0;
                end
            end
            rd_row_q <= '0;
        end else begin
            rd_row_q <= mat_q[rd_chip][rd_ax];
            if (do_commit) begin
                mat_q[cap_chip_q][cap_ax_q][cap_ay_q] <= cap_data_q;
            end
            for (int x = 0; x < 16; x++) begin
                if (reset_sw1_q) mat_q[0][x] <= '0;
                if (reset_sw2_q) mat_q[1][x] <= '0;
            end
        end
    end

    // New error sets are OR-ed in after the clear so they survive clr_err.
    always_comb begin
        err_d    = clr_err ? 4'b0000 : err_q;
        err_d[0] = err_d[0] | ((state_q == StCommit) && (strobe_cnt_q < MinStrobe));
        err_d[1] = err_d[1] | ((state_q == StStrobeHi) && bus_changed);
        err_d[2] = err_d[2] | ((state_q == StIdle) && strobe_rise && setup_bad);
        err_d[3] = err_d[3] | both_cs;
        cnt_d    = clr_err ? '0 : cnt_q;
        if (do_commit && cnt_d != '1) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_row       = rd_row_q;
    assign err          = err_q;
    assign commit_count = cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mt8816_switch_model.sv
// Scoreboard bench for mt8816_switch_model: directed bus sequences queue expected
// readback/status values, and a monitor compares them when each result is presented.
module tb_mt8816_switch_model;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             RESET_SW1 = 1'b0, CS_SW1 = 1'b0, RESET_SW2 = 1'b0, CS_SW2 = 1'b0;
    logic             STROBE = 1'b0, DATA = 1'b0;
    logic [3:0]       AX = '0;
    logic [2:0]       AY = '0;
    logic             rd_chip = 1'b0;
    logic [3:0]       rd_ax = '0;
    logic [7:0]       rd_row;
    logic             clr_err = 1'b0;
    logic [3:0]       err;
    logic [CNT_W-1:0] commit_count;
    logic             busy;

    typedef enum int {KRow, KErr, KCnt, KBusy} kind_e;
    typedef struct {
        kind_e kind;
        int    exp;
        string name;
    } item_t;

    item_t sb[$];
    logic  chk_req = 1'b0;
    logic  chk_arm = 1'b0;
    int    n_cmp = 0;
    int    n_fail = 0;

    mt8816_switch_model #(
        .MIN_STROBE(3),
        .MIN_SETUP (1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RESET_SW1   (RESET_SW1),
        .CS_SW1      (CS_SW1),
        .RESET_SW2   (RESET_SW2),
        .CS_SW2      (CS_SW2),
        .AX          (AX),
        .AY          (AY),
        .STROBE      (STROBE),
        .DATA        (DATA),
        .rd_chip     (rd_chip),
        .rd_ax       (rd_ax),
        .rd_row      (rd_row),
        .clr_err     (clr_err),
        .err         (err),
        .commit_count(commit_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // A request issued before an edge is presented by the DUT after that edge.
    always @(posedge clk) chk_arm <= chk_req;

    always @(negedge clk) begin : monitor
        item_t it;
        int    act;
        if (chk_arm) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got a check strobe, required a queued item");
            end else begin
                it = sb.pop_front();
                case (it.kind)
                    KRow:    act = int'(rd_row);
                    KErr:    act = int'(err);
                    KCnt:    act = int'(commit_count);
                    default: act = int'(busy);
                endcase
                if (act != it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h required 0x%0h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_item(input kind_e k, input int exp, input string name);
        item_t it;
        it.kind = k;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
    endtask

    task automatic expect_row(input logic chip, input logic [3:0] ax, input logic [7:0] exp,
                              input string name);
        rd_chip = chip;
        rd_ax   = ax;
        expect_item(KRow, int'(exp), $sformatf("%s row c%0d ax%0d", name, chip, ax));
    endtask

    task automatic expect_status(input logic [3:0] e, input int cnt, input string name);
        expect_item(KErr, int'(e), {name, " err"});
        expect_item(KCnt, cnt, {name, " commit_count"});
        expect_item(KBusy, 0, {name, " busy"});
    endtask

    task automatic do_write(input logic chip, input logic [3:0] ax, input logic [2:0] ay,
                            input logic d, input int hi);
        CS_SW1 = ~chip;
        CS_SW2 = chip;
        AX     = ax;
        AY     = ay;
        DATA   = d;
        tick();
        STROBE = 1'b1;
        repeat (hi) tick();
        STROBE = 1'b0;
        tick();
        CS_SW1 = 1'b0;
        CS_SW2 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with random bus activity
        repeat (3) begin
            {RESET_SW1, CS_SW1, RESET_SW2, CS_SW2, STROBE, DATA} = 6'($urandom);
            AX = 4'($urandom);
            AY = 3'($urandom);
            tick();
        end
        {RESET_SW1, CS_SW1, RESET_SW2, CS_SW2, STROBE, DATA} = '0;
        AX    = '0;
        AY    = '0;
        rst_n = 1'b1;
        repeat (2) tick();
        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
                expect_row(c[0], x[3:0], 8'h00, "reset");
            end
        end
        expect_status(4'b0000, 0, "reset");

        // Nominal write
        do_write(1'b0, 4'd5, 3'd3, 1'b1, 3);
        expect_row(1'b0, 4'd5, 8'h08, "nominal");
        expect_row(1'b1, 4'd5, 8'h00, "nominal other chip");
        expect_status(4'b0000, 1, "nominal");

        // Close/open on SW2, then RESET_SW2
        do_write(1'b1, 4'd12, 3'd7, 1'b1, 3);
        expect_row(1'b1, 4'd12, 8'h80, "close sw2");
        do_write(1'b1, 4'd12, 3'd7, 1'b0, 3);
        expect_row(1'b1, 4'd12, 8'h00, "open sw2");
        do_write(1'b1, 4'd0, 3'd0, 1'b1, 3);
        do_write(1'b1, 4'd15, 3'd1, 1'b1, 3);
        expect_row(1'b1, 4'd0, 8'h01, "close sw2 corner");
        expect_row(1'b1, 4'd15, 8'h02, "close sw2 corner");
        RESET_SW2 = 1'b1;
        tick();
        RESET_SW2 = 1'b0;
        repeat (3) tick();
        expect_row(1'b1, 4'd0, 8'h00, "reset_sw2");
        expect_row(1'b1, 4'd12, 8'h00, "reset_sw2");
        expect_row(1'b1, 4'd15, 8'h00, "reset_sw2");
        expect_row(1'b0, 4'd5, 8'h08, "reset_sw2 keeps sw1");
        expect_status(4'b0000, 5, "reset_sw2");

        // Short strobe still commits
        do_write(1'b0, 4'd7, 3'd2, 1'b1, 2);
        expect_row(1'b0, 4'd7, 8'h04, "short strobe");
        expect_status(4'b0001, 6, "short strobe");
        pulse_clr();
        expect_status(4'b0000, 0, "clr_err");

        // AY changes mid-strobe; write uses the captured AY
        CS_SW1 = 1'b1;
        AX     = 4'd9;
        AY     = 3'd3;
        DATA   = 1'b1;
        tick();
        STROBE = 1'b1;
        tick();
        AY = 3'd4;
        repeat (2) tick();
        STROBE = 1'b0;
        tick();
        CS_SW1 = 1'b0;
        repeat (4) tick();
        expect_row(1'b0, 4'd9, 8'h08, "ay change");
        expect_status(4'b0010, 1, "ay change");
        pulse_clr();

        // Strobe with no chip select
        AX   = 4'd3;
        AY   = 3'd0;
        DATA = 1'b1;
        tick();
        STROBE = 1'b1;
        repeat (3) tick();
        STROBE = 1'b0;
        repeat (5) tick();
        expect_row(1'b0, 4'd3, 8'h00, "no cs");
        expect_row(1'b1, 4'd3, 8'h00, "no cs");
        expect_status(4'b0100, 0, "no cs");
        pulse_clr();

        // Both chip selects high for one cycle
        CS_SW1 = 1'b1;
        CS_SW2 = 1'b1;
        tick();
        CS_SW1 = 1'b0;
        CS_SW2 = 1'b0;
        repeat (2) tick();
        expect_status(4'b1000, 0, "both cs");
        pulse_clr();
        expect_status(4'b0000, 0, "both cs cleared");

        // rst_n during STROBE_HI aborts the write
        CS_SW1 = 1'b1;
        AX     = 4'd2;
        AY     = 3'd6;
        DATA   = 1'b1;
        tick();
        STROBE = 1'b1;
        repeat (2) tick();
        expect_item(KBusy, 1, "busy mid strobe");
        rst_n  = 1'b0;
        STROBE = 1'b0;
        CS_SW1 = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_item(KBusy, 0, "busy after rst");
        repeat (4) tick();
        expect_row(1'b0, 4'd2, 8'h00, "rst abort");
        expect_row(1'b0, 4'd5, 8'h00, "rst clears matrix");
        expect_status(4'b0000, 0, "rst abort");

        // RESET_SW1 high through the COMMIT cycle blocks the write
        CS_SW1 = 1'b1;
        AX     = 4'd4;
        AY     = 3'd1;
        DATA   = 1'b1;
        tick();
        STROBE = 1'b1;
        repeat (3) tick();
        STROBE    = 1'b0;
        RESET_SW1 = 1'b1;
        repeat (2) tick();
        RESET_SW1 = 1'b0;
        CS_SW1    = 1'b0;
        repeat (4) tick();
        expect_row(1'b0, 4'd4, 8'h00, "reset in commit");
        expect_status(4'b0000, 0, "reset in commit");
        do_write(1'b0, 4'd4, 3'd1, 1'b1, 3);
        expect_row(1'b0, 4'd4, 8'h02, "write after reset");
        expect_status(4'b0000, 1, "write after reset");

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d items pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
